// File: rtl/cond_logic.sv
// Condition unit: holds the {N,Z,C,V} flag register and gates architectural write requests.
// Latency: a condition evaluated in the Issue cycle gates the outputs from the next cycle on. Flags become visible one cycle after they are written.
// Backpressure: none; every input is accepted every cycle, and the gated outputs are combinational.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic       Issue,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondExHeld
);

    // Flag bit positions: [3]=N, [2]=Z, [1]=C, [0]=V
    logic [3:0] r_flags;
    logic       r_cond_ex_held;
    logic       w_cond_ex;
    logic       w_n, w_z, w_c, w_v;
    logic       w_flag_we_nz;
    logic       w_flag_we_cv;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluate the ARM condition code against the registered (pre-update) flags
    always_comb begin
        w_cond_ex = 1'b1;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;  // AL, and 1111 is treated as always
        endcase
    end

    // Flag writes use the held result of the instruction in flight, not the one issuing now
    assign w_flag_we_nz = FlagW[1] & r_cond_ex_held;
    assign w_flag_we_cv = FlagW[0] & r_cond_ex_held;

    // Latch the condition result on Issue; hold it for the rest of the instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cond_ex_held <= 1'b0;
        end else if (Issue) begin
            r_cond_ex_held <= w_cond_ex;
        end
    end

    // N,Z and C,V update independently under their own enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_flag_we_nz) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flag_we_cv) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Gating is purely combinational, so an async reset drops the outputs at once
    assign PCSrc      = PCS  & r_cond_ex_held;
    assign RegWrite   = RegW & r_cond_ex_held;
    assign MemWrite   = MemW & r_cond_ex_held;
    assign Flags      = r_flags;
    assign CondExHeld = r_cond_ex_held;

endmodule

// File: doc/cond_logic.md
# cond_logic

Condition unit on the consuming side of the ALU's {N,Z,C,V} flag interface. Holds the architectural flag register and loads it from `ALUFlags` under per-group write enables. Evaluates a 4-bit ARM-style condition code against the stored flags when an instruction issues, then gates the controller's register-write, memory-write and PC-write requests for the rest of that instruction. Sits between the main decoder and the datapath of the multicycle processor.

## Interface
- No parameters; widths are fixed by the 4-bit flag and condition encodings.
- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `Issue`  in  1  strobe; the instruction's condition is evaluated this cycle.
- `Cond`  in  4  condition field; sampled only when `Issue`=1.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the current operation.
- `FlagW`  in  2  [1] requests an N,Z update; [0] requests a C,V update.
- `PCS`  in  1  PC-write request from the decoder.
- `RegW`  in  1  register-write request.
- `MemW`  in  1  memory-write request.
- `PCSrc`  out  1  `PCS` gated by the held condition.
- `RegWrite`  out  1  `RegW` gated by the held condition.
- `MemWrite`  out  1  `MemW` gated by the held condition.
- `Flags`  out  4  registered {N,Z,C,V}.
- `CondExHeld`  out  1  latched condition result of the current instruction.

## Operation
- Flag bit order is [3]=N, [2]=Z, [1]=C, [0]=V throughout.
- CondEx is a combinational function of `Cond` and the registered `Flags`:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 1 (treated as always).
- On a rising edge with `Issue`=1: `CondExHeld` <= CondEx. With `Issue`=0, `CondExHeld` holds.
- Flag-write enable for N,Z is `FlagW[1] & CondExHeld`. On that edge, `Flags[3:2]` <= `ALUFlags[3:2]`.
- Flag-write enable for C,V is `FlagW[0] & CondExHeld`. On that edge, `Flags[1:0]` <= `ALUFlags[1:0]`.
- The two flag groups update independently. Flag writes are never gated by `Issue`.
- Output gating is combinational:
  - `PCSrc` = `PCS` & `CondExHeld`.
  - `RegWrite` = `RegW` & `CondExHeld`.
  - `MemWrite` = `MemW` & `CondExHeld`.
- A failed condition squashes all architectural writes and flag updates until the next `Issue`.

## Timing
- Reset, asserted asynchronously: `Flags`=0000 and `CondExHeld`=0. Therefore `PCSrc`, `RegWrite` and `MemWrite` are 0 regardless of the request inputs.
- Reset release: the first instruction must `Issue` before any write can be enabled.
- Evaluation latency: `Cond` is evaluated in the `Issue` cycle N, and the result gates outputs from cycle N+1 onward.
- The gated outputs follow `PCS`/`RegW`/`MemW` with zero latency within a cycle.
- Flag latency: flags are written at the end of the cycle in which `FlagW` is asserted and are visible on `Flags` the next cycle.
- Simultaneous `Issue` and flag write in the same cycle:
  - The new CondEx uses the pre-update `Flags`.
  - The flag-write enable uses the old `CondExHeld`.
  - Both registers update on the same edge.
- Back-to-back `Issue` on every cycle is legal; each evaluation uses flags as registered at that edge.
- `reset` asserted mid-instruction: outputs drop to 0 immediately, without waiting for a clock edge.
- `Cond` and `ALUFlags` are don't-care in cycles where they are not sampled.

## Test plan
- Reset, then `PCS`=`RegW`=`MemW`=1 with no `Issue` -> `Flags`=0000 and all three gated outputs stay 0.
- Set up flags: `Issue`, `Cond`=1110, next cycle `FlagW`=11 with `ALUFlags`=1000 (result of 2-5) -> `Flags`=1000 the following cycle.
- With `Flags`=1000, issue each of 0100 MI, 1011 LT and 0000 EQ -> `CondExHeld` = 1, 1, 0 respectively, and `RegWrite` follows `RegW`=1 accordingly.
- Failed condition: with `Flags`=1000, `Issue` `Cond`=0000, then `FlagW`=11 with `ALUFlags`=0100 -> `Flags` stays 1000 and `MemWrite`=0 while `MemW`=1.
- Partial write: `Flags`=0000, AL issued, `FlagW`=01 with `ALUFlags`=1111 -> `Flags`=0011. Then `FlagW`=10 with `ALUFlags`=0100 -> `Flags`=0111.
- Simultaneous events:
  - With `Flags`=0100, `CondExHeld`=1 and `FlagW`=10, issue `Cond`=0000 EQ with `ALUFlags`=0000 in the same cycle.
  - Required: `CondExHeld`=1 (old Z used) and `Flags`=0000 next cycle.
  - Then assert async `reset` mid-cycle: outputs drop to 0 immediately.
